// File: rtl/llki_pkg.sv
// LLKI shared definitions: the key-sender state type, command opcodes,
// response status codes and the command legality check.
package llki_pkg;

    typedef enum logic [2:0] {
        ST_IDLE               = 3'd0,
        ST_LOAD_WAIT_READY    = 3'd1,
        ST_LOAD_VALID         = 3'd2,
        ST_LOAD_WAIT_ACCEPT   = 3'd3,
        ST_LOAD_WAIT_COMPLETE = 3'd4,
        ST_CLEAR_WAIT_ACK     = 3'd5,
        ST_RESP               = 3'd6
    } LLKID_SENDER_STATE_TYPE;

    localparam logic [1:0] LLKID_OP_LOAD  = 2'd1;
    localparam logic [1:0] LLKID_OP_CLEAR = 2'd2;

    localparam logic [1:0] LLKID_STATUS_OK      = 2'd0;
    localparam logic [1:0] LLKID_STATUS_TIMEOUT = 2'd1;
    localparam logic [1:0] LLKID_STATUS_BAD_CMD = 2'd2;

    // A command is rejected for an unknown opcode, or for a LOAD whose word
    // count is zero or larger than the key store can hold. The word count
    // carries no meaning for CLEAR, so it is not checked there.
    function automatic logic llkid_cmd_bad(input logic [1:0] op,
                                           input logic [7:0] num_words,
                                           input logic [7:0] max_words);
        logic bad;
        bad = 1'b0;
        if (op != LLKID_OP_LOAD && op != LLKID_OP_CLEAR)
            bad = 1'b1;
        else if (op == LLKID_OP_LOAD && (num_words == 8'd0 || num_words > max_words))
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/llkid_key_sender.sv
// LLKI discrete key sender (initiator side).
// Takes a LOAD or CLEAR command, reads key words from a key store by index
// and hands them one 64-bit word at a time to a technique-specific shim
// (TSS) over the ready/valid/complete handshake, or requests a key clear.
// Every command ends with a one-cycle response carrying OK, TIMEOUT or
// BAD_CMD. A wait state that runs for TIMEOUT_CYCLES aborts the load and
// falls back to clearing the TSS key.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op, cmd_num_words opcode (1 LOAD, 2 CLEAR) and LOAD word count
//   key_word_idx          key store read index (current word counter)
//   key_word_data         key store data, combinational on key_word_idx
//   rsp_valid, rsp_status one-cycle response pulse, status held until next
//   llkid_key_data/valid  word to the TSS, one-cycle strobe
//   llkid_key_ready       TSS can accept a word
//   llkid_key_complete    TSS has the whole key
//   llkid_clear_key(_ack) clear request (level) and its acknowledge
module llkid_key_sender
    import llki_pkg::*;
#(
    parameter int MAX_KEY_WORDS  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_num_words,
    output logic [7:0]  key_word_idx,
    input  logic [63:0] key_word_data,
    output logic        rsp_valid,
    output logic [1:0]  rsp_status,
    output logic [63:0] llkid_key_data,
    output logic        llkid_key_valid,
    input  logic        llkid_key_ready,
    input  logic        llkid_key_complete,
    output logic        llkid_clear_key,
    input  logic        llkid_clear_key_ack
);

    localparam logic [7:0]  MAX_WORDS = 8'(MAX_KEY_WORDS);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    LLKID_SENDER_STATE_TYPE state, state_nxt;

    logic [7:0]  word_cnt_nxt;
    logic [7:0]  num_words, num_words_nxt;
    logic [15:0] tmo_cnt, tmo_cnt_nxt;
    logic        abort, abort_nxt;
    logic [63:0] key_data_nxt;
    logic        key_valid_nxt;
    logic        rsp_valid_nxt;
    logic [1:0]  rsp_status_nxt;
    logic        clear_nxt;
    logic        cmd_ready_nxt;
    logic        tmo_hit;

    // The state has now been occupied for TIMEOUT_CYCLES cycles.
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            key_word_idx    <= '0;
            num_words       <= '0;
            tmo_cnt         <= '0;
            abort           <= 1'b0;
            llkid_key_data  <= '0;
            llkid_key_valid <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_status      <= LLKID_STATUS_OK;
            llkid_clear_key <= 1'b0;
            cmd_ready       <= 1'b1;
        end else begin
            state           <= state_nxt;
            key_word_idx    <= word_cnt_nxt;
            num_words       <= num_words_nxt;
            tmo_cnt         <= tmo_cnt_nxt;
            abort           <= abort_nxt;
            llkid_key_data  <= key_data_nxt;
            llkid_key_valid <= key_valid_nxt;
            rsp_valid       <= rsp_valid_nxt;
            rsp_status      <= rsp_status_nxt;
            llkid_clear_key <= clear_nxt;
            cmd_ready       <= cmd_ready_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        word_cnt_nxt   = key_word_idx;
        num_words_nxt  = num_words;
        abort_nxt      = abort;
        key_data_nxt   = llkid_key_data;
        key_valid_nxt  = 1'b0;
        rsp_status_nxt = rsp_status;

        case (state)
            ST_IDLE: begin
                word_cnt_nxt = '0;
                abort_nxt    = 1'b0;
                if (cmd_valid) begin
                    if (llkid_cmd_bad(cmd_op, cmd_num_words, MAX_WORDS)) begin
                        rsp_status_nxt = LLKID_STATUS_BAD_CMD;
                        state_nxt      = ST_RESP;
                    end else if (cmd_op == LLKID_OP_LOAD) begin
                        num_words_nxt = cmd_num_words;
                        state_nxt     = ST_LOAD_WAIT_READY;
                    end else begin
                        state_nxt = ST_CLEAR_WAIT_ACK;
                    end
                end
            end

            ST_LOAD_WAIT_READY: begin
                if (tmo_hit) begin
                    abort_nxt = 1'b1;
                    state_nxt = ST_CLEAR_WAIT_ACK;
                end else if (llkid_key_ready) begin
                    key_data_nxt  = key_word_data;
                    key_valid_nxt = 1'b1;
                    state_nxt     = ST_LOAD_VALID;
                end
            end

            ST_LOAD_VALID: begin
                state_nxt = ST_LOAD_WAIT_ACCEPT;
            end

            // The TSS dropping ready is its acknowledgement of the word.
            ST_LOAD_WAIT_ACCEPT: begin
                if (tmo_hit) begin
                    abort_nxt = 1'b1;
                    state_nxt = ST_CLEAR_WAIT_ACK;
                end else if (!llkid_key_ready) begin
                    if (key_word_idx == num_words - 8'd1) begin
                        state_nxt = ST_LOAD_WAIT_COMPLETE;
                    end else begin
                        word_cnt_nxt = key_word_idx + 8'd1;
                        state_nxt    = ST_LOAD_WAIT_READY;
                    end
                end
            end

            ST_LOAD_WAIT_COMPLETE: begin
                if (tmo_hit) begin
                    abort_nxt = 1'b1;
                    state_nxt = ST_CLEAR_WAIT_ACK;
                end else if (llkid_key_complete) begin
                    rsp_status_nxt = LLKID_STATUS_OK;
                    state_nxt      = ST_RESP;
                end
            end

            // Entered either by command or by an aborted load; the abort
            // flag decides which status an acknowledged clear reports.
            ST_CLEAR_WAIT_ACK: begin
                if (llkid_clear_key_ack) begin
                    rsp_status_nxt = abort ? LLKID_STATUS_TIMEOUT : LLKID_STATUS_OK;
                    state_nxt      = ST_RESP;
                end else if (tmo_hit) begin
                    rsp_status_nxt = LLKID_STATUS_TIMEOUT;
                    state_nxt      = ST_RESP;
                end
            end

            ST_RESP: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Registered outputs that follow the state being entered.
        rsp_valid_nxt = (state_nxt == ST_RESP);
        clear_nxt     = (state_nxt == ST_CLEAR_WAIT_ACK);
        cmd_ready_nxt = (state_nxt == ST_IDLE);

        // Restart the timeout count on every state change; idle never times out.
        if (state == ST_IDLE || state_nxt != state)
            tmo_cnt_nxt = '0;
        else
            tmo_cnt_nxt = tmo_cnt + 16'd1;
    end

endmodule

// File: tb/tb_llkid_key_sender.sv
module tb_llkid_key_sender;

    localparam logic [63:0] KEY0 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] KEY1 = 64'h2222_2222_2222_2222;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_num_words = 8'd0;
    logic [7:0]  key_word_idx;
    logic [63:0] key_word_data;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [63:0] llkid_key_data;
    logic        llkid_key_valid;
    logic        llkid_key_ready;
    logic        llkid_key_complete;
    logic        llkid_clear_key;
    logic        llkid_clear_key_ack;

    int vectors = 0;
    int miscompares = 0;

    // Responder (TSS) model with two key words and fault-injection knobs.
    logic [127:0] tss_reg;
    logic [1:0]   tss_k;
    logic         tss_rdy, tss_cmp, tss_ack;
    logic         stuck_rdy = 1'b0;
    logic         stuck_ack = 1'b0;

    always #5 clk = ~clk;

    assign key_word_data = (key_word_idx == 8'd0) ? KEY0 :
                           (key_word_idx == 8'd1) ? KEY1 : 64'h0;

    assign llkid_key_ready     = tss_rdy & ~stuck_rdy;
    assign llkid_key_complete  = tss_cmp;
    assign llkid_clear_key_ack = tss_ack;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tss_reg <= '0;
            tss_k   <= 2'd0;
            tss_rdy <= 1'b1;
            tss_cmp <= 1'b0;
            tss_ack <= 1'b0;
        end else begin
            if (llkid_key_valid && tss_k < 2'd2) begin
                if (tss_k == 2'd0) tss_reg[63:0] <= llkid_key_data;
                else               tss_reg[127:64] <= llkid_key_data;
                tss_k   <= tss_k + 2'd1;
                tss_rdy <= 1'b0;
                tss_cmp <= 1'b0;
            end else if (!tss_rdy) begin
                tss_rdy <= 1'b1;
                if (tss_k == 2'd2) tss_cmp <= 1'b1;
            end
            tss_ack <= llkid_clear_key & ~stuck_ack;
            if (llkid_clear_key && !stuck_ack) begin
                tss_reg <= '0;
                tss_k   <= 2'd0;
                tss_cmp <= 1'b0;
                tss_rdy <= 1'b1;
            end
        end
    end

    llkid_key_sender #(
        .MAX_KEY_WORDS (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_op             (cmd_op),
        .cmd_num_words      (cmd_num_words),
        .key_word_idx       (key_word_idx),
        .key_word_data      (key_word_data),
        .rsp_valid          (rsp_valid),
        .rsp_status         (rsp_status),
        .llkid_key_data     (llkid_key_data),
        .llkid_key_valid    (llkid_key_valid),
        .llkid_key_ready    (llkid_key_ready),
        .llkid_key_complete (llkid_key_complete),
        .llkid_clear_key    (llkid_clear_key),
        .llkid_clear_key_ack(llkid_clear_key_ack)
    );

    // Called #1 after an edge with the DUT idle; returns #1 after the accept edge.
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] nw);
        cmd_op        = op;
        cmd_num_words = nw;
        cmd_valid     = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
        vectors++; if (rsp_status !== 2'd0) begin miscompares++; $display("FAIL reset_rsp_status got %0d want 0", rsp_status); end
        vectors++; if (key_word_idx !== 8'd0) begin miscompares++; $display("FAIL reset_idx got %0d want 0", key_word_idx); end
        vectors++; if (llkid_key_data !== 64'd0) begin miscompares++; $display("FAIL reset_key_data got %h want 0", llkid_key_data); end
        vectors++; if (llkid_key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_key_valid got %0b want 0", llkid_key_valid); end
        vectors++; if (llkid_clear_key !== 1'b0) begin miscompares++; $display("FAIL reset_clear got %0b want 0", llkid_clear_key); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // LOAD of two words; n counts edges after the accept edge.
    task automatic run_load(input string tag);
        int pulses, first_valid, got;
        logic [1:0] st;
        pulses = 0; first_valid = -1; got = 0; st = 2'd3;
        send_cmd(2'd1, 8'd2);
        for (int n = 0; n < 60; n++) begin
            if (llkid_key_valid) begin
                pulses++;
                if (first_valid < 0) first_valid = n;
            end
            if (rsp_valid) begin got = 1; st = rsp_status; break; end
            @(posedge clk);
            #1;
        end
        vectors++; if (got !== 1) begin miscompares++; $display("FAIL %s_rsp_seen got %0d want 1", tag, got); end
        vectors++; if (first_valid !== 1) begin miscompares++; $display("FAIL %s_first_valid_cycle got %0d want 1", tag, first_valid); end
        vectors++; if (pulses !== 2) begin miscompares++; $display("FAIL %s_valid_pulses got %0d want 2", tag, pulses); end
        vectors++; if (tss_reg !== {KEY1, KEY0}) begin miscompares++; $display("FAIL %s_tss_reg got %h want %h", tag, tss_reg, {KEY1, KEY0}); end
        vectors++; if (st !== 2'd0) begin miscompares++; $display("FAIL %s_status got %0d want 0", tag, st); end
        @(posedge clk);
        #1;
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL %s_ready_after got %0b want 1", tag, cmd_ready); end
    endtask

    task automatic test_load;
        run_load("load");
    endtask

    task automatic test_clear;
        int first_clear, got, extra;
        logic [1:0] st;
        logic clr_at_rsp;
        first_clear = -1; got = 0; extra = 0; st = 2'd3; clr_at_rsp = 1'b1;
        send_cmd(2'd2, 8'd1);
        for (int n = 0; n < 40; n++) begin
            if (llkid_clear_key && first_clear < 0) first_clear = n;
            if (rsp_valid) begin got = 1; st = rsp_status; clr_at_rsp = llkid_clear_key; break; end
            @(posedge clk);
            #1;
        end
        vectors++; if (first_clear !== 0) begin miscompares++; $display("FAIL clear_assert_cycle got %0d want 0", first_clear); end
        vectors++; if (got !== 1) begin miscompares++; $display("FAIL clear_rsp_seen got %0d want 1", got); end
        vectors++; if (st !== 2'd0) begin miscompares++; $display("FAIL clear_status got %0d want 0", st); end
        vectors++; if (clr_at_rsp !== 1'b0) begin miscompares++; $display("FAIL clear_dropped got %0b want 0", clr_at_rsp); end
        vectors++; if (tss_reg !== 128'd0) begin miscompares++; $display("FAIL clear_tss_reg got %h want 0", tss_reg); end
        // The ack is still high for a cycle here; it must not start anything.
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || llkid_clear_key) extra++;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL clear_stale_ack got %0d events want 0", extra); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL clear_ready_after got %0b want 1", cmd_ready); end
    endtask

    task automatic test_bad_cmd;
        logic [1:0] ops [4] = '{2'd1, 2'd1, 2'd3, 2'd0};
        logic [7:0] nws [4] = '{8'd0, 8'd9, 8'd1, 8'd1};
        for (int i = 0; i < 4; i++) begin
            int act;
            act = 0;
            send_cmd(ops[i], nws[i]);
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bad%0d_rsp_valid got %0b want 1", i, rsp_valid); end
            vectors++; if (rsp_status !== 2'd2) begin miscompares++; $display("FAIL bad%0d_status got %0d want 2", i, rsp_status); end
            for (int n = 0; n < 4; n++) begin
                if (llkid_key_valid || llkid_clear_key) act++;
                @(posedge clk);
                #1;
            end
            vectors++; if (act !== 0) begin miscompares++; $display("FAIL bad%0d_llki_activity got %0d want 0", i, act); end
            vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL bad%0d_ready_after got %0b want 1", i, cmd_ready); end
        end
    endtask

    task automatic test_timeout_ready;
        int first_clear, got;
        logic [1:0] st;
        first_clear = -1; got = 0; st = 2'd3;
        stuck_rdy = 1'b1;
        send_cmd(2'd1, 8'd2);
        for (int n = 0; n < 80; n++) begin
            if (llkid_clear_key && first_clear < 0) first_clear = n;
            if (rsp_valid) begin got = 1; st = rsp_status; break; end
            @(posedge clk);
            #1;
        end
        vectors++; if (first_clear !== 16) begin miscompares++; $display("FAIL tmo_rdy_clear_cycle got %0d want 16", first_clear); end
        vectors++; if (got !== 1) begin miscompares++; $display("FAIL tmo_rdy_rsp_seen got %0d want 1", got); end
        vectors++; if (st !== 2'd1) begin miscompares++; $display("FAIL tmo_rdy_status got %0d want 1", st); end
        stuck_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_timeout_both;
        int first_clear, rsp_n;
        logic [1:0] st;
        logic clr_at_rsp;
        first_clear = -1; rsp_n = -1; st = 2'd3; clr_at_rsp = 1'b1;
        stuck_rdy = 1'b1;
        stuck_ack = 1'b1;
        send_cmd(2'd1, 8'd2);
        for (int n = 0; n < 80; n++) begin
            if (llkid_clear_key && first_clear < 0) first_clear = n;
            if (rsp_valid) begin rsp_n = n; st = rsp_status; clr_at_rsp = llkid_clear_key; break; end
            @(posedge clk);
            #1;
        end
        vectors++; if (first_clear !== 16) begin miscompares++; $display("FAIL tmo_both_clear_cycle got %0d want 16", first_clear); end
        vectors++; if (rsp_n !== 32) begin miscompares++; $display("FAIL tmo_both_rsp_cycle got %0d want 32", rsp_n); end
        vectors++; if (st !== 2'd1) begin miscompares++; $display("FAIL tmo_both_status got %0d want 1", st); end
        vectors++; if (clr_at_rsp !== 1'b0) begin miscompares++; $display("FAIL tmo_both_clear_dropped got %0b want 0", clr_at_rsp); end
        stuck_rdy = 1'b0;
        stuck_ack = 1'b0;
        @(posedge clk);
        #1;
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL tmo_both_ready_after got %0b want 1", cmd_ready); end
    endtask

    task automatic test_midop_reset;
        send_cmd(2'd1, 8'd2);
        @(posedge clk);
        #1;
        vectors++; if (llkid_key_valid !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_valid got %0b want 1", llkid_key_valid); end
        rst_n = 1'b0;
        #1;
        vectors++; if (llkid_key_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got %0b want 0", llkid_key_valid); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready got %0b want 1", cmd_ready); end
        vectors++; if (llkid_key_data !== 64'd0) begin miscompares++; $display("FAIL rst_mid_key_data got %h want 0", llkid_key_data); end
        vectors++; if (key_word_idx !== 8'd0) begin miscompares++; $display("FAIL rst_mid_idx got %0d want 0", key_word_idx); end
        vectors++; if (rsp_status !== 2'd0) begin miscompares++; $display("FAIL rst_mid_status got %0d want 0", rsp_status); end
        vectors++; if (llkid_clear_key !== 1'b0) begin miscompares++; $display("FAIL rst_mid_clear got %0b want 0", llkid_clear_key); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_load("reload");
    endtask

    initial begin
        test_reset();
        test_load();
        test_clear();
        test_bad_cmd();
        test_timeout_ready();
        test_timeout_both();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
